// File: rtl/prio_arb_enc.sv
// Registered priority arbiter/encoder.
// N request lines compete for one shared resource. The winner is reported as a
// binary index (Y) and as a one-hot grant. A grant is held until the winner
// pulses done, drops its request, or EN goes low. MODE selects between fixed
// priority (highest index wins) and round-robin.
module prio_arb_enc #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] Din,
  input  logic         done,
  output logic [W-1:0] Y,
  output logic [N-1:0] grant,
  output logic         valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   last_q, last_d;
  logic [N-1:0]   grant_q, grant_d;

  logic [W-1:0]   win_s;
  logic           found_s;
  logic           release_s;
  int             start_s;
  int             idx_s;

  // Winner selection: fixed priority picks the highest set bit; round-robin
  // searches downward from last-1, wrapping to N-1 (modulo N, not 2^W).
  always_comb begin
    win_s   = {W{1'b0}};
    found_s = 1'b0;
    start_s = 0;
    idx_s   = 0;
    if (MODE == 0) begin
      for (int k = 0; k < N; k++) begin
        win_s = Din[k] ? W'(k) : win_s;
      end
    end else begin
      start_s = (last_q == {W{1'b0}}) ? (N - 1) : (int'(last_q) - 1);
      for (int k = 0; k < N; k++) begin
        idx_s = start_s - k;
        if (idx_s < 0) begin
          idx_s = idx_s + N;
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && Din[idx_s]) begin
          win_s   = W'(idx_s);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // A held grant ends on EN low, a done pulse, or the winner withdrawing.
  always_comb begin
    release_s = (!EN) || done || (!Din[y_q]);
  end

  // Next-state and datapath: Y holds its last value after release so the
  // index stays readable during the bubble cycle.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (EN && (Din != {N{1'b0}})) begin
          state_d = BUSY;
          y_d     = win_s;
          last_d  = win_s;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_s;
        end else begin
          state_d = IDLE;
          grant_d = {N{1'b0}};
        end
      end
      BUSY: begin
        if (release_s) begin
          state_d = IDLE;
          grant_d = {N{1'b0}};
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {N{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset (also clears the RR pointer).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= {W{1'b0}};
      last_q  <= {W{1'b0}};
      grant_q <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Y     = y_q;
    grant = grant_q;
    valid = (state_q == BUSY);
  end

endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: one fixed-priority and one round-robin instance share
// the same inputs and are compared every cycle against a behavioural model.
module tb_prio_arb_enc;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [7:0] din;
  logic [2:0] y0, y1;
  logic [7:0] g0, g1;
  logic       v0, v1;

  int errors = 0;
  int checks = 0;

  int m_valid [2];
  int m_y     [2];
  int m_last  [2];

  always #10 clk = ~clk;

  prio_arb_enc #(.N(N), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .EN(en), .Din(din), .done(done),
    .Y(y0), .grant(g0), .valid(v0)
  );

  prio_arb_enc #(.N(N), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .EN(en), .Din(din), .done(done),
    .Y(y1), .grant(g1), .valid(v1)
  );

  function automatic int pick(int mode, int last, logic [7:0] req);
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (last + N - k) % N;
        if (req[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0; m_y[m] = 0; m_last[m] = 0;
      end else if (m_valid[m] != 0) begin
        if (!en || done || !din[m_y[m]]) m_valid[m] = 0;
      end else if (en && din != 8'h00) begin
        m_y[m]     = pick(m, m_last[m], din);
        m_last[m]  = m_y[m];
        m_valid[m] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    eg = (m_valid[0] != 0) ? (8'h01 << m_y[0]) : 8'h00;
    chk("fp_valid", {31'b0, v0}, m_valid[0]);
    chk("fp_y",     {29'b0, y0}, m_y[0]);
    chk("fp_grant", {24'b0, g0}, {24'b0, eg});
    eg = (m_valid[1] != 0) ? (8'h01 << m_y[1]) : 8'h00;
    chk("rr_valid", {31'b0, v1}, m_valid[1]);
    chk("rr_y",     {29'b0, y1}, m_y[1]);
    chk("rr_grant", {24'b0, g1}, {24'b0, eg});
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_y[m] = 0; m_last[m] = 0;
    end
    rst = 1'b1; en = 1'b1; din = 8'hFF; done = 1'b0;

    // 1. reset held two cycles with all requests up
    step(); step();
    chk("rst_valid0", {31'b0, v0}, 32'd0);
    chk("rst_grant1", {24'b0, g1}, 32'd0);
    rst = 1'b0;
    step();
    chk("first_grant_y", {29'b0, y1}, 32'd7);
    chk("first_grant_v", {31'b0, v0}, 32'd1);

    // 2. fixed priority pick, hold, done release, re-grant after bubble
    en = 1'b0; step();
    en = 1'b1; din = 8'b0010_0110; step();
    chk("fp_pick5", {29'b0, y0}, 32'd5);
    chk("fp_grant5", {24'b0, g0}, 32'h20);
    for (int i = 0; i < 5; i++) step();
    chk("fp_held", {31'b0, v0}, 32'd1);
    done = 1'b1; step();
    chk("fp_released", {31'b0, v0}, 32'd0);
    done = 1'b0; step();
    chk("fp_regrant5", {29'b0, y0}, 32'd5);

    // 3. round-robin rotation from a fresh pointer
    rst = 1'b1; step();
    rst = 1'b0; din = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      done = 1'b0; step();
      chk("rr_seq", {29'b0, y1}, (15 - i) % 8);
      done = 1'b1; step();
      chk("rr_bubble", {31'b0, v1}, 32'd0);
    end

    // 4. two requesters alternate, then a lone requester repeats
    din = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      done = 1'b0; step();
      done = 1'b1; step();
    end
    din = 8'b0000_0001;
    for (int i = 0; i < 3; i++) begin
      done = 1'b0; step();
      chk("rr_lone0", {29'b0, y1}, 32'd0);
      done = 1'b1; step();
    end
    done = 1'b0;

    // 5. abort by EN, then release by withdrawal and re-grant to 6
    din = 8'b0000_1000; step();
    chk("busy3", {29'b0, y1}, 32'd3);
    en = 1'b0; step();
    chk("en_abort", {31'b0, v1}, 32'd0);
    en = 1'b1; step();
    din = 8'b0100_0000; step();
    chk("withdraw", {31'b0, v0}, 32'd0);
    step();
    chk("regrant6", {29'b0, y0}, 32'd6);

    // 6. reset mid-grant clears the RR pointer
    din = 8'b0001_0000; step(); step(); step();
    chk("busy4", {29'b0, y1}, 32'd4);
    rst = 1'b1; step();
    chk("rst_mid", {24'b0, g1}, 32'd0);
    rst = 1'b0; din = 8'hFF; step();
    chk("ptr_reset7", {29'b0, y1}, 32'd7);
    en = 1'b0; step();
    en = 1'b1; din = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("no_req", {31'b0, v1}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 9) != 0);
      done = ($urandom_range(0, 3) == 0);
      din  = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7))
                                         : 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
